onehot_decoder_seq: RTL and testbench

- Parametrised, registered binary-to-one-hot decoder: generalises the fixed 4-to-16 combinational decoder to arbitrary select width and output count.
- Adds a valid/ready load interface, out-of-range detection, and an autonomous scan mode that walks the active bit up or down with a programmable dwell time.
- Intended uses are row/column strobing, chip-select sequencing and walking-one test patterns.

---
 rtl/onehot_decoder_seq.sv | 155 +++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with valid/ready load,
// out-of-range detection and a dwell-timed walking scan mode.
module onehot_decoder_seq #(
    parameter int SEL_W   = 4,
    parameter int N_OUT   = 16,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_OUT-1:0]   out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap,
    output logic               err
);

    if (N_OUT < 2 || N_OUT > (1 << SEL_W)) begin : g_bad_n_out
        $error("onehot_decoder_seq: N_OUT must be in [2, 2**SEL_W]");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SCAN_UP,
        S_SCAN_DN,
        S_HOLD
    } state_e;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

    state_e             state_q, state_d;
    logic [N_OUT-1:0]   out_q, out_d;
    logic               ov_q, ov_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;

    logic               entry;
    logic               step;
    logic [SEL_W-1:0]   start;

    function automatic logic [N_OUT-1:0] one_hot(input logic [SEL_W-1:0] i);
        one_hot = N_OUT'(1) << i;
    endfunction

    assign in_ready  = en && (mode == 2'b00);
    assign out       = out_q;
    assign out_valid = ov_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
    assign err       = err_q;

    // Target state for this edge, chosen directly from en and mode
    always_comb begin
        state_d = S_IDLE;
        if (en) begin
            unique case (mode)
                2'b00:   state_d = S_DECODE;
                2'b01:   state_d = S_SCAN_UP;
                2'b10:   state_d = S_SCAN_DN;
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Next output/index/counter values for the selected state
    always_comb begin
        out_d  = out_q;
        ov_d   = ov_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        entry  = (state_d != state_q);
        // Counter wrap forces a step so a lowered dwell never stalls the scan
        step   = (cnt_q == dwell) || (cnt_q == '1);
        start  = ov_q ? idx_q : ((state_d == S_SCAN_UP) ? '0 : LAST);
        unique case (state_d)
            S_IDLE: begin
                out_d = '0;
                ov_d  = 1'b0;
                cnt_d = '0;
            end
            S_DECODE: begin
                cnt_d = '0;
                if (in_valid) begin
                    if (int'(sel) < N_OUT) begin
                        out_d = one_hot(sel);
                        ov_d  = 1'b1;
                        idx_d = sel;
                    end else begin
                        out_d = '0;
                        ov_d  = 1'b0;
                        err_d = 1'b1;
                    end
                end
            end
            S_SCAN_UP, S_SCAN_DN: begin
                if (entry) begin
                    idx_d = start;
                    out_d = one_hot(start);
                    ov_d  = 1'b1;
                    cnt_d = '0;
                end else if (step) begin
                    cnt_d = '0;
                    if (state_d == S_SCAN_UP) begin
                        wrap_d = (idx_q == LAST);
                        idx_d  = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        wrap_d = (idx_q == '0);
                        idx_d  = (idx_q == '0) ? LAST : idx_q - 1'b1;
                    end
                    out_d = one_hot(idx_d);
                    ov_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                if (entry) begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            ov_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed scoreboard bench for onehot_decoder_seq (N_OUT=16 and
// N_OUT=10 instances driven from the same stimulus).
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [3:0] sel;
    logic [7:0] dwell;

    logic        rdy_a, ov_a, wrap_a, err_a;
    logic [15:0] out_a;
    logic [3:0]  idx_a;
    logic        rdy_b, ov_b, wrap_b, err_b;
    logic [9:0]  out_b;
    logic [3:0]  idx_b;

    onehot_decoder_seq #(.SEL_W(4), .N_OUT(16), .DWELL_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_a), .sel(sel), .dwell(dwell),
        .out(out_a), .out_valid(ov_a), .idx(idx_a), .wrap(wrap_a), .err(err_a)
    );

    onehot_decoder_seq #(.SEL_W(4), .N_OUT(10), .DWELL_W(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_b), .sel(sel), .dwell(dwell),
        .out(out_b), .out_valid(ov_b), .idx(idx_b), .wrap(wrap_b), .err(err_b)
    );

    typedef struct packed {
        logic [15:0] o;
        logic        v;
        logic [3:0]  i;
        logic        w;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic use_b    = 1'b0;

    function automatic exp_t ex(input logic [15:0] o, input logic v,
                                input logic [3:0] i, input logic w,
                                input logic e);
        ex = '{o: o, v: v, i: i, w: w, e: e};
    endfunction

    task automatic cyc(input exp_t e, input string tag);
        exp_t want, got;
        q.push_back(e);
        @(posedge clk);
        #1;
        want = q.pop_front();
        if (use_b) got = ex({6'b0, out_b}, ov_b, idx_b, wrap_b, err_b);
        else       got = ex(out_a, ov_a, idx_a, wrap_a, err_a);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic chk_rdy(input logic want, input string tag);
        #1;
        checks++;
        assert (rdy_a === want) else begin
            failures++;
            $error("FAIL %s in_ready got=%b exp=%b", tag, rdy_a, want);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00;
        in_valid = 1'b0; sel = '0; dwell = '0;

        // reset
        cyc(ex(16'h0, 0, 0, 0, 0), "reset0");
        cyc(ex(16'h0, 0, 0, 0, 0), "reset1");

        // decode back-to-back
        rst_n = 1'b1; en = 1'b1; mode = 2'b00; in_valid = 1'b1; sel = 4'd0;
        chk_rdy(1'b1, "rdy_decode");
        cyc(ex(16'h0001, 1, 0, 0, 0), "dec0");
        sel = 4'd5;
        cyc(ex(16'h0020, 1, 5, 0, 0), "dec5");
        sel = 4'd15;
        cyc(ex(16'h8000, 1, 15, 0, 0), "dec15");
        in_valid = 1'b0; sel = 4'd2;
        cyc(ex(16'h8000, 1, 15, 0, 0), "dec_hold");

        // out of range on N_OUT=10
        use_b = 1'b1;
        in_valid = 1'b1; sel = 4'd9;
        cyc(ex(16'h0200, 1, 9, 0, 0), "oor_9");
        sel = 4'd12;
        cyc(ex(16'h0000, 0, 9, 0, 1), "oor_12");
        in_valid = 1'b0;
        cyc(ex(16'h0000, 0, 9, 0, 0), "oor_err_clr");
        use_b = 1'b0;

        // scan up from reset, dwell=2
        rst_n = 1'b0;
        cyc(ex(16'h0, 0, 0, 0, 0), "reset2");
        rst_n = 1'b1; mode = 2'b01; dwell = 8'd2;
        chk_rdy(1'b0, "rdy_scan");
        for (int p = 0; p < 16; p++)
            for (int k = 0; k < 3; k++)
                cyc(ex(16'(1) << p, 1, 4'(p), 0, 0), "scan_up");
        cyc(ex(16'h0001, 1, 0, 1, 0), "scan_up_wrap");
        cyc(ex(16'h0001, 1, 0, 0, 0), "scan_up_post0");
        cyc(ex(16'h0001, 1, 0, 0, 0), "scan_up_post1");

        // scan down after decode, dwell=0
        mode = 2'b00; in_valid = 1'b1; sel = 4'd3;
        cyc(ex(16'h0008, 1, 3, 0, 0), "dn_dec3");
        in_valid = 1'b0; mode = 2'b10; dwell = 8'd0;
        cyc(ex(16'h0008, 1, 3, 0, 0), "dn_entry");
        cyc(ex(16'h0004, 1, 2, 0, 0), "dn_2");
        cyc(ex(16'h0002, 1, 1, 0, 0), "dn_1");
        cyc(ex(16'h0001, 1, 0, 0, 0), "dn_0");
        cyc(ex(16'h8000, 1, 15, 1, 0), "dn_wrap");
        cyc(ex(16'h4000, 1, 14, 0, 0), "dn_14");

        // hold and disable
        mode = 2'b00; in_valid = 1'b1; sel = 4'd4;
        cyc(ex(16'h0010, 1, 4, 0, 0), "h_dec4");
        in_valid = 1'b0; mode = 2'b01;
        cyc(ex(16'h0010, 1, 4, 0, 0), "h_entry");
        cyc(ex(16'h0020, 1, 5, 0, 0), "h_5");
        cyc(ex(16'h0040, 1, 6, 0, 0), "h_6");
        mode = 2'b11;
        chk_rdy(1'b0, "rdy_hold");
        for (int k = 0; k < 5; k++)
            cyc(ex(16'h0040, 1, 6, 0, 0), "hold");
        mode = 2'b01;
        cyc(ex(16'h0040, 1, 6, 0, 0), "resume_entry");
        cyc(ex(16'h0080, 1, 7, 0, 0), "resume_7");
        en = 1'b0; mode = 2'b00;
        chk_rdy(1'b0, "rdy_disabled");
        cyc(ex(16'h0000, 0, 7, 0, 0), "dis0");
        cyc(ex(16'h0000, 0, 7, 0, 0), "dis1");

        // reset mid-scan at idx 11, dwell=4
        en = 1'b1; mode = 2'b00; in_valid = 1'b1; sel = 4'd9;
        cyc(ex(16'h0200, 1, 9, 0, 0), "r_dec9");
        in_valid = 1'b0; mode = 2'b01; dwell = 8'd4;
        for (int k = 0; k < 5; k++)
            cyc(ex(16'h0200, 1, 9, 0, 0), "r_9");
        for (int k = 0; k < 5; k++)
            cyc(ex(16'h0400, 1, 10, 0, 0), "r_10");
        cyc(ex(16'h0800, 1, 11, 0, 0), "r_11");
        rst_n = 1'b0;
        cyc(ex(16'h0000, 0, 0, 0, 0), "r_mid");
        rst_n = 1'b1; dwell = 8'd5;
        for (int k = 0; k < 4; k++)
            cyc(ex(16'h0001, 1, 0, 0, 0), "r_restart");

        // dwell lowered below the running count: step at counter wrap
        dwell = 8'd1;
        for (int k = 0; k < 252; k++)
            cyc(ex(16'h0001, 1, 0, 0, 0), "lowdw_wait");
        cyc(ex(16'h0002, 1, 1, 0, 0), "lowdw_step");
        cyc(ex(16'h0002, 1, 1, 0, 0), "lowdw_dw1");
        cyc(ex(16'h0004, 1, 2, 0, 0), "lowdw_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
